// File: rtl/dsp_pkg.sv
// Shared types and constants for the parallel serializer: FSM encoding,
// overflow counter width and lane-counter sizing helper.
package dsp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int unsigned OVF_CNT_W = 16;

  // Lane counter needs at least one bit even when a word holds a single lane.
  function automatic int unsigned cnt_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/parallel_serializer_pingpong_buffer.sv
// Two-entry ping-pong word store with sync bits, pointers and full flags.
// Exposes next-cycle read-entry contents so the top can register its outputs.
module pingpong_buffer #(
  parameter int unsigned WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PARALLEL_SERIALIZER_OVF_EN
  output logic             overflow,
`endif
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_sync,
  input  logic             rd_free,
  output logic [WIDTH-1:0] nxt_rd_data,
  output logic             nxt_rd_sync,
  output logic             nxt_occupied
);

  logic [WIDTH-1:0] mem [2];
  logic [1:0]       sync_q;
  logic [1:0]       full_q;
  logic             wr_ptr;
  logic             rd_ptr;

  logic [1:0] full_freed;
  logic [1:0] full_n;
  logic       wr_accept;
  logic       rd_ptr_n;
  logic       wr_ptr_n;

  // Freeing is applied before the write test so a full buffer can accept a
  // word in the same cycle its read entry is released.
  always_comb begin
    full_freed = full_q;
    if (rd_free) full_freed[rd_ptr] = 1'b0;
    wr_accept = wr_en & ~full_freed[wr_ptr];
    full_n    = full_freed;
    if (wr_accept) full_n[wr_ptr] = 1'b1;
    rd_ptr_n  = rd_ptr ^ rd_free;
    wr_ptr_n  = wr_ptr ^ wr_accept;
    if (wr_accept && (wr_ptr == rd_ptr_n)) begin
      nxt_rd_data = wr_data;
      nxt_rd_sync = wr_sync;
    end else begin
      nxt_rd_data = mem[rd_ptr_n];
      nxt_rd_sync = sync_q[rd_ptr_n];
    end
    nxt_occupied = |full_n;
  end

`ifdef PARALLEL_SERIALIZER_OVF_EN
  assign overflow = wr_en & ~wr_accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      sync_q <= '0;
      full_q <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr_accept) begin
        mem[wr_ptr]    <= wr_data;
        sync_q[wr_ptr] <= wr_sync;
      end
      full_q <= full_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
    end
  end

endmodule

// File: rtl/parallel_serializer.sv
// Parallel-to-serial converter: one DIN_WIDTH*PARALLEL word in, PARALLEL samples out.
// Optional overflow tracking (warning + ovf_count) under PARALLEL_SERIALIZER_OVF_EN.
module parallel_serializer
  import dsp_pkg::*;
#(
  parameter int unsigned DIN_WIDTH = 9,
  parameter int unsigned PARALLEL  = 4,
  parameter string       DATA_TYPE = "signed"
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIN_WIDTH*PARALLEL-1:0] din,
  input  logic                          din_valid,
  input  logic                          sync_in,
  output logic [DIN_WIDTH-1:0]          dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last,
  output logic                          sync_out,
`ifdef PARALLEL_SERIALIZER_OVF_EN
  output logic [OVF_CNT_W-1:0]          ovf_count,
`endif
  output logic                          warning
);

  localparam int unsigned WORD_W = DIN_WIDTH * PARALLEL;
  localparam int unsigned CNT_W  = cnt_width(PARALLEL);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PARALLEL - 1);

  // Sample interpretation is carried only as metadata; reject unknown tags.
  if (DATA_TYPE != "signed" && DATA_TYPE != "unsigned") begin : g_bad_type
    $error("parallel_serializer: DATA_TYPE must be \"signed\" or \"unsigned\"");
  end

  ser_state_t        state;
  ser_state_t        state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic              consume;
  logic              last_consume;
  logic [WORD_W-1:0] nxt_word;
  logic              nxt_sync;
  logic              nxt_occupied;
  logic [DIN_WIDTH-1:0] dout_d;
  logic              dout_valid_d;
  logic              dout_last_d;
  logic              sync_out_d;
`ifdef PARALLEL_SERIALIZER_OVF_EN
  logic              overflow;
`endif

  assign consume      = dout_valid & dout_ready;
  assign last_consume = consume & (cnt == LAST_LANE);

  pingpong_buffer #(
    .WIDTH (WORD_W)
  ) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef PARALLEL_SERIALIZER_OVF_EN
    .overflow     (overflow),
`endif
    .wr_en        (din_valid),
    .wr_data      (din),
    .wr_sync      (sync_in),
    .rd_free      (last_consume),
    .nxt_rd_data  (nxt_word),
    .nxt_rd_sync  (nxt_sync),
    .nxt_occupied (nxt_occupied)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      sync_out   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      dout_last  <= dout_last_d;
      sync_out   <= sync_out_d;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (nxt_occupied)  state_n = SHIFT;
      SHIFT:   if (!nxt_occupied) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from next-cycle state so they can be registered
  // while still giving one-cycle latency and no bubble between words.
  always_comb begin
    cnt_n = cnt;
    if (last_consume)  cnt_n = '0;
    else if (consume)  cnt_n = cnt + CNT_W'(1);
    dout_valid_d = (state_n == SHIFT);
    dout_d       = '0;
    if (dout_valid_d) dout_d = nxt_word[int'(cnt_n) * DIN_WIDTH +: DIN_WIDTH];
    dout_last_d  = dout_valid_d & (cnt_n == LAST_LANE);
    sync_out_d   = dout_valid_d & (cnt_n == '0) & nxt_sync;
  end

`ifdef PARALLEL_SERIALIZER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warning   <= 1'b0;
      ovf_count <= '0;
    end else if (overflow) begin
      warning <= 1'b1;
      if (ovf_count != '1) ovf_count <= ovf_count + OVF_CNT_W'(1);
    end
  end
`else
  assign warning = 1'b0;
`endif

endmodule

// File: tb/tb_parallel_serializer.sv
// Self-checking bench for parallel_serializer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_parallel_serializer;

  localparam int W    = 9;
  localparam int P    = 4;
  localparam int WORD = W * P;

  logic            clk;
  logic            rst_n;
  logic [WORD-1:0] din;
  logic            din_valid;
  logic            sync_in;
  logic [W-1:0]    dout;
  logic            dout_valid;
  logic            dout_ready;
  logic            dout_last;
  logic            sync_out;
  logic            warning;
`ifdef PARALLEL_SERIALIZER_OVF_EN
  logic [15:0]     ovf_count;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: queue of accepted words ({sync, word}) and current lane.
  logic [WORD:0] m_q[$];
  int            m_lane = 0;
  int            m_ovf  = 0;
  logic [W-1:0]  got_q[$];

  parallel_serializer #(
    .DIN_WIDTH (W),
    .PARALLEL  (P),
    .DATA_TYPE ("signed")
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sync_in    (sync_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .sync_out   (sync_out),
`ifdef PARALLEL_SERIALIZER_OVF_EN
    .ovf_count  (ovf_count),
`endif
    .warning    (warning)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_valid();
    return m_q.size() > 0;
  endfunction

  function automatic logic [W-1:0] exp_dout();
    logic [WORD:0] e;
    if (m_q.size() == 0) return '0;
    e = m_q[0];
    return e[m_lane*W +: W];
  endfunction

  function automatic logic exp_last();
    return (m_q.size() > 0) && (m_lane == P - 1);
  endfunction

  function automatic logic exp_sync();
    logic [WORD:0] e;
    if (m_q.size() == 0) return 1'b0;
    e = m_q[0];
    return (m_lane == 0) && e[WORD];
  endfunction

  function automatic logic exp_warning();
`ifdef PARALLEL_SERIALIZER_OVF_EN
    return m_ovf > 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] lane_of(input logic [WORD-1:0] w, input int k);
    return w[k*W +: W];
  endfunction

  function automatic logic [WORD-1:0] rand_word();
    logic [WORD-1:0] w;
    for (int i = 0; i < P; i++) w[i*W +: W] = W'($urandom);
    return w;
  endfunction

  // One clock: drive at the falling edge, advance the model at the rising
  // edge, return at the next falling edge where outputs are sampled.
  task automatic cycle(input logic v, input logic [WORD-1:0] d, input logic s, input logic r);
    din_valid  = v;
    din        = d;
    sync_in    = s;
    dout_ready = r;
    if (dout_valid === 1'b1 && r) got_q.push_back(dout);
    @(posedge clk);
    if (m_q.size() > 0 && r) begin
      m_lane++;
      if (m_lane == P) begin
        m_lane = 0;
        void'(m_q.pop_front());
      end
    end
    if (v) begin
      if (m_q.size() < 2) m_q.push_back({s, d});
      else m_ovf++;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_lane = 0;
    m_ovf  = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = '0; din_valid = 1'b0; sync_in = 1'b0; dout_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout got=%0h exp=0", dout); end
    total++; if (dout_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", dout_last); end
    total++; if (sync_out !== 1'b0) begin bad++; $display("FAIL reset_sync got=%b exp=0", sync_out); end
    total++; if (warning !== 1'b0) begin bad++; $display("FAIL reset_warning got=%b exp=0", warning); end
`ifdef PARALLEL_SERIALIZER_OVF_EN
    total++; if (ovf_count !== 16'd0) begin bad++; $display("FAIL reset_ovf_count got=%0d exp=0", ovf_count); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [WORD-1:0] w;
    w = {9'd3, 9'd2, 9'd1, 9'd0};
    cycle(1'b1, w, 1'b0, 1'b1);
    for (int k = 0; k < P; k++) begin
      total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL single_valid lane=%0d got=%b exp=1", k, dout_valid); end
      total++; if (dout !== W'(k)) begin bad++; $display("FAIL single_dout lane=%0d got=%0d exp=%0d", k, dout, k); end
      total++; if (dout_last !== (k == P - 1)) begin bad++; $display("FAIL single_last lane=%0d got=%b exp=%b", k, dout_last, (k == P - 1)); end
      cycle(1'b0, '0, 1'b0, 1'b1);
    end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", dout_valid); end
  endtask

  task automatic test_back_to_back();
    logic [WORD-1:0] w0, w1, ws;
    w0 = rand_word();
    w1 = rand_word();
    for (int c = 0; c < 2 * P; c++) begin
      cycle((c == 0) || (c == P), (c < P) ? w0 : w1, 1'b0, 1'b1);
      ws = (c < P) ? w0 : w1;
      total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid c=%0d got=%b exp=1", c, dout_valid); end
      total++; if (dout !== lane_of(ws, c % P)) begin bad++; $display("FAIL b2b_dout c=%0d got=%0h exp=%0h", c, dout, lane_of(ws, c % P)); end
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", dout_valid); end
    total++; if (warning !== 1'b0) begin bad++; $display("FAIL b2b_warning got=%b exp=0", warning); end
  endtask

  task automatic test_backpressure();
    logic [WORD-1:0] w;
    w = rand_word();
    got_q.delete();
    cycle(1'b1, w, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      total++; if (dout_valid !== 1'b1 || dout !== lane_of(w, 2)) begin
        bad++; $display("FAIL bp_hold i=%0d got=%b/%0h exp=1/%0h", i, dout_valid, dout, lane_of(w, 2));
      end
    end
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    total++; if (got_q.size() != P) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), P); end
    for (int k = 0; k < P && k < got_q.size(); k++) begin
      total++; if (got_q[k] !== lane_of(w, k)) begin bad++; $display("FAIL bp_sample k=%0d got=%0h exp=%0h", k, got_q[k], lane_of(w, k)); end
    end
  endtask

  task automatic test_overflow();
    logic [WORD-1:0] w0, w1, w2;
    w0 = rand_word(); w1 = rand_word(); w2 = rand_word();
    cycle(1'b1, w0, 1'b0, 1'b0);
    cycle(1'b1, w1, 1'b0, 1'b0);
    total++; if (warning !== 1'b0) begin bad++; $display("FAIL ovf_early_warning got=%b exp=0", warning); end
    cycle(1'b1, w2, 1'b0, 1'b0);
`ifdef PARALLEL_SERIALIZER_OVF_EN
    total++; if (warning !== 1'b1) begin bad++; $display("FAIL ovf_warning got=%b exp=1", warning); end
    total++; if (ovf_count !== 16'd1) begin bad++; $display("FAIL ovf_count got=%0d exp=1", ovf_count); end
`else
    total++; if (warning !== 1'b0) begin bad++; $display("FAIL ovf_warning_off got=%b exp=0", warning); end
`endif
    got_q.delete();
    repeat (2 * P + 2) cycle(1'b0, '0, 1'b0, 1'b1);
    total++; if (got_q.size() != 2 * P) begin bad++; $display("FAIL ovf_stream_len got=%0d exp=%0d", got_q.size(), 2 * P); end
    for (int k = 0; k < 2 * P && k < got_q.size(); k++) begin
      total++; if (got_q[k] !== lane_of((k < P) ? w0 : w1, k % P)) begin
        bad++; $display("FAIL ovf_sample k=%0d got=%0h exp=%0h", k, got_q[k], lane_of((k < P) ? w0 : w1, k % P));
      end
    end
  endtask

  task automatic test_sync();
    logic [WORD-1:0] w0, w1;
    int hits;
    w0 = rand_word(); w1 = rand_word();
    hits = 0;
    for (int c = 0; c < 2 * P + 1; c++) begin
      cycle((c == 0) || (c == P), (c == 0) ? w0 : w1, (c == P), 1'b1);
      total++; if (sync_out !== exp_sync()) begin bad++; $display("FAIL sync_flag c=%0d got=%b exp=%b", c, sync_out, exp_sync()); end
      if (sync_out === 1'b1) begin
        hits++;
        total++; if (dout !== lane_of(w1, 0)) begin bad++; $display("FAIL sync_lane0 got=%0h exp=%0h", dout, lane_of(w1, 0)); end
      end
    end
    total++; if (hits != 1) begin bad++; $display("FAIL sync_count got=%0d exp=1", hits); end
  endtask

  task automatic test_reset_mid();
    logic [WORD-1:0] w, w2;
    w = rand_word(); w2 = rand_word();
    cycle(1'b1, w, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    total++; if (dout !== lane_of(w, 2)) begin bad++; $display("FAIL rst_mid_pre got=%0h exp=%0h", dout, lane_of(w, 2)); end
    rst_n = 1'b0;
    #1;
    model_reset();
    total++; if ({dout_valid, dout_last, sync_out, warning} !== 4'b0) begin
      bad++; $display("FAIL rst_mid_flags got=%b exp=0000", {dout_valid, dout_last, sync_out, warning});
    end
    total++; if (dout !== '0) begin bad++; $display("FAIL rst_mid_dout got=%0h exp=0", dout); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, w2, 1'b0, 1'b1);
    total++; if (dout_valid !== 1'b1 || dout !== lane_of(w2, 0) || dout_last !== 1'b0) begin
      bad++; $display("FAIL rst_mid_restart got=%b/%0h/%b exp=1/%0h/0", dout_valid, dout, dout_last, lane_of(w2, 0));
    end
    repeat (P) cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic v, s, r;
    for (int c = 0; c < 300; c++) begin
      v = ($urandom_range(0, 2) == 0);
      s = $urandom_range(0, 1);
      r = ($urandom_range(0, 3) != 0);
      cycle(v, rand_word(), s, r);
      total++; if (dout_valid !== exp_valid()) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, dout_valid, exp_valid()); end
      if (exp_valid()) begin
        total++; if (dout !== exp_dout()) begin bad++; $display("FAIL rnd_dout c=%0d got=%0h exp=%0h", c, dout, exp_dout()); end
      end
      total++; if (dout_last !== exp_last()) begin bad++; $display("FAIL rnd_last c=%0d got=%b exp=%b", c, dout_last, exp_last()); end
      total++; if (sync_out !== exp_sync()) begin bad++; $display("FAIL rnd_sync c=%0d got=%b exp=%b", c, sync_out, exp_sync()); end
      total++; if (warning !== exp_warning()) begin bad++; $display("FAIL rnd_warning c=%0d got=%b exp=%b", c, warning, exp_warning()); end
`ifdef PARALLEL_SERIALIZER_OVF_EN
      total++; if (ovf_count !== 16'(m_ovf)) begin bad++; $display("FAIL rnd_ovf_count c=%0d got=%0d exp=%0d", c, ovf_count, m_ovf); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_sync();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
